// File: rtl/pipe_pkg.sv
// Shared types and constants for the decode-side hazard controller:
// FSM encoding, forwarding select codes and the scoreboard slot layout.
package pipe_pkg;

   localparam int NREG_DEF  = 16;
   localparam int REG_IDX_W = $clog2(NREG_DEF);

   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_LU_STALL = 2'd1,
      ST_FLUSH    = 2'd2,
      ST_MEM_WAIT = 2'd3
   } hz_state_t;

   // One-hot operand source selects; bit 3 is reserved and always 0.
   localparam logic [3:0] FWD_NONE = 4'b0000;
   localparam logic [3:0] FWD_EX   = 4'b0001;
   localparam logic [3:0] FWD_MEM  = 4'b0010;
   localparam logic [3:0] FWD_WB   = 4'b0100;

   typedef struct packed {
      logic     valid;
      reg_idx_t rd;
      logic     we;
      logic     is_load;
   } sb_slot_t;

   localparam sb_slot_t SLOT_EMPTY = '0;

   // A slot produces a source operand only for a real decode instruction that
   // actually reads that source.
   function automatic logic slot_match(sb_slot_t s, reg_idx_t src, logic use_src,
                                       logic id_valid);
      return s.valid & s.we & (s.rd == src) & use_src & id_valid;
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode-side bundle between the pipeline datapath (master) and the hazard
// controller (slave). There is no valid/ready handshake here: id_valid only
// qualifies the decode fields in the same cycle, and every enable/select the
// controller returns is combinational and valid in that same cycle.
interface pipeline_hazard_ctrl_if;
   import pipe_pkg::*;

   logic       id_valid;
   reg_idx_t   id_ra;
   reg_idx_t   id_rb;
   logic       id_use_a;
   logic       id_use_b;
   reg_idx_t   id_rd;
   logic       id_reg_write;
   logic       id_mem_read;
   logic       ex_branch_taken;
   logic       mem_busy;

   logic       pc_en;
   logic       fd_en;
   logic       fd_flush;
   logic       de_en;
   logic       de_bubble;
   logic [3:0] fwd_a_sel;
   logic [3:0] fwd_b_sel;
   logic [1:0] hazard_state;

   modport master (
      output id_valid, id_ra, id_rb, id_use_a, id_use_b, id_rd,
             id_reg_write, id_mem_read, ex_branch_taken, mem_busy,
      input  pc_en, fd_en, fd_flush, de_en, de_bubble,
             fwd_a_sel, fwd_b_sel, hazard_state
   );

   modport slave (
      input  id_valid, id_ra, id_rb, id_use_a, id_use_b, id_rd,
             id_reg_write, id_mem_read, ex_branch_taken, mem_busy,
      output pc_en, fd_en, fd_flush, de_en, de_bubble,
             fwd_a_sel, fwd_b_sel, hazard_state
   );

endinterface

// File: rtl/pipe_scoreboard.sv
// Three-slot record of in-flight register writes (EX, MEM, WB) with the
// operand match, forwarding priority and load-use detection.
module pipe_scoreboard
   import pipe_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       advance,
   input  sb_slot_t   push,
   input  logic       id_valid,
   input  reg_idx_t   id_ra,
   input  reg_idx_t   id_rb,
   input  logic       id_use_a,
   input  logic       id_use_b,
   output logic [3:0] fwd_a_sel,
   output logic [3:0] fwd_b_sel,
   output logic       load_use
);

   sb_slot_t ex_q, mem_q, wb_q;
   logic     hit_ex_a, hit_mem_a, hit_wb_a;
   logic     hit_ex_b, hit_mem_b, hit_wb_b;

   // Once an instruction reaches WB its load flag has no consumer.
   logic     unused_wb_load;
   assign unused_wb_load = wb_q.is_load;

   // Youngest producer wins; a load still in EX has no result to forward.
   function automatic logic [3:0] pick(logic ex_hit, logic ex_load,
                                       logic mem_hit, logic wb_hit);
      if (ex_hit && !ex_load) return FWD_EX;
      else if (mem_hit)       return FWD_MEM;
      else if (wb_hit)        return FWD_WB;
      else                    return FWD_NONE;
   endfunction

   // Shift the slots forward only when the decode/execute latch loads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q  <= SLOT_EMPTY;
         mem_q <= SLOT_EMPTY;
         wb_q  <= SLOT_EMPTY;
      end else if (advance) begin
         ex_q  <= push;
         mem_q <= ex_q;
         wb_q  <= mem_q;
      end
   end

   // Match both sources against the pre-advance slots.
   always_comb begin
      hit_ex_a  = slot_match(ex_q,  id_ra, id_use_a, id_valid);
      hit_mem_a = slot_match(mem_q, id_ra, id_use_a, id_valid);
      hit_wb_a  = slot_match(wb_q,  id_ra, id_use_a, id_valid);
      hit_ex_b  = slot_match(ex_q,  id_rb, id_use_b, id_valid);
      hit_mem_b = slot_match(mem_q, id_rb, id_use_b, id_valid);
      hit_wb_b  = slot_match(wb_q,  id_rb, id_use_b, id_valid);
      fwd_a_sel = pick(hit_ex_a, ex_q.is_load, hit_mem_a, hit_wb_a);
      fwd_b_sel = pick(hit_ex_b, ex_q.is_load, hit_mem_b, hit_wb_b);
      load_use  = ex_q.is_load & (hit_ex_a | hit_ex_b);
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer beside decode: owns every latch enable in the core and
// the forwarding selects that travel with each instruction into execute.
module pipeline_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int BR_PENALTY = 1,
   parameter int NREG       = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   pipeline_hazard_ctrl_if.slave bus
);

   if ($clog2(NREG) != REG_IDX_W || BR_PENALTY < 0 || BR_PENALTY > 3) begin : g_param_check
      $error("pipeline_hazard_ctrl: unsupported NREG or BR_PENALTY");
   end

   localparam logic [1:0] PENALTY = 2'(BR_PENALTY);

   hz_state_t  state_q, state_d;
   hz_state_t  saved_q, saved_d;
   hz_state_t  eff_state;
   logic [1:0] cnt_q, cnt_d;
   logic       pc_en, fd_en, fd_flush, de_en, de_bubble;
   logic       load_use;
   logic       push_valid;
   sb_slot_t   push;

   // Squashed decode instructions enter EX as empty slots.
   always_comb begin
      push_valid = bus.id_valid & ~de_bubble;
      push = '{valid:   push_valid,
               rd:      bus.id_rd,
               we:      push_valid & bus.id_reg_write,
               is_load: push_valid & bus.id_mem_read};
   end

   pipe_scoreboard u_sb (
      .clk       (clk),
      .rst_n     (rst_n),
      .advance   (de_en),
      .push      (push),
      .id_valid  (bus.id_valid),
      .id_ra     (bus.id_ra),
      .id_rb     (bus.id_rb),
      .id_use_a  (bus.id_use_a),
      .id_use_b  (bus.id_use_b),
      .fwd_a_sel (bus.fwd_a_sel),
      .fwd_b_sel (bus.fwd_b_sel),
      .load_use  (load_use)
   );

   // State, state saved across a memory wait, and flush down-counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         saved_q <= ST_RUN;
         cnt_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         saved_q <= saved_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state and enables; mem_busy beats a taken branch beats load-use.
   always_comb begin
      state_d   = state_q;
      saved_d   = saved_q;
      cnt_d     = cnt_q;
      pc_en     = 1'b0;
      fd_en     = 1'b0;
      fd_flush  = 1'b0;
      de_en     = 1'b0;
      de_bubble = 1'b0;
      // A finished memory wait re-runs the state it interrupted.
      eff_state = (state_q == ST_MEM_WAIT) ? saved_q : state_q;
      if (!rst_n) begin
         state_d = ST_RUN;
      end else if (bus.mem_busy) begin
         state_d = ST_MEM_WAIT;
         saved_d = eff_state;
      end else if (bus.ex_branch_taken) begin
         pc_en     = 1'b1;
         fd_en     = 1'b1;
         fd_flush  = 1'b1;
         de_en     = 1'b1;
         de_bubble = 1'b1;
         cnt_d     = PENALTY;
         state_d   = (BR_PENALTY > 0) ? ST_FLUSH : ST_RUN;
      end else begin
         case (eff_state)
            ST_FLUSH: begin
               pc_en     = 1'b1;
               fd_en     = 1'b1;
               fd_flush  = 1'b1;
               de_en     = 1'b1;
               de_bubble = 1'b1;
               if (cnt_q <= 2'd1) begin
                  cnt_d   = 2'd0;
                  state_d = ST_RUN;
               end else begin
                  cnt_d   = cnt_q - 2'd1;
                  state_d = ST_FLUSH;
               end
            end
            ST_RUN: begin
               if (load_use) begin
                  de_en     = 1'b1;
                  de_bubble = 1'b1;
                  state_d   = ST_LU_STALL;
               end else begin
                  pc_en   = 1'b1;
                  fd_en   = 1'b1;
                  de_en   = 1'b1;
                  state_d = ST_RUN;
               end
            end
            default: begin
               // LU_STALL: the load sits in MEM now, so the consumer advances.
               pc_en   = 1'b1;
               fd_en   = 1'b1;
               de_en   = 1'b1;
               state_d = ST_RUN;
            end
         endcase
      end
   end

   assign bus.pc_en        = pc_en;
   assign bus.fd_en        = fd_en;
   assign bus.fd_flush     = fd_flush;
   assign bus.de_en        = de_en;
   assign bus.de_bubble    = de_bubble;
   assign bus.hazard_state = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (BR_PENALTY=1, NREG=16).
module tb_pipeline_hazard_ctrl;

   typedef struct packed {
      logic       rst;
      logic       v;
      logic [3:0] ra;
      logic [3:0] rb;
      logic       ua;
      logic       ub;
      logic [3:0] rd;
      logic       we;
      logic       ld;
      logic       br;
      logic       busy;
   } stim_t;

   logic        clk;
   logic        rst_n;
   int          checks;
   int          passed;
   logic [14:0] exp_q[$];
   logic [14:0] want;
   logic [14:0] obs;

   pipeline_hazard_ctrl_if bus ();

   pipeline_hazard_ctrl #(.BR_PENALTY(1), .NREG(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   assign obs = {bus.pc_en, bus.fd_en, bus.fd_flush, bus.de_en, bus.de_bubble,
                 bus.fwd_a_sel, bus.fwd_b_sel, bus.hazard_state};

   // Clock and initial reset level.
   initial begin
      clk   = 1'b0;
      rst_n = 1'b0;
   end
   always #5 clk = ~clk;

   function automatic stim_t mk(logic v, logic [3:0] ra, logic [3:0] rb,
                                logic ua, logic ub, logic [3:0] rd,
                                logic we, logic ld, logic br, logic busy);
      stim_t s;
      s = '{rst: 1'b1, v: v, ra: ra, rb: rb, ua: ua, ub: ub, rd: rd,
            we: we, ld: ld, br: br, busy: busy};
      return s;
   endfunction

   function automatic logic [14:0] ev(logic pc, logic fd, logic fl, logic de,
                                      logic bb, logic [3:0] fa, logic [3:0] fb,
                                      logic [1:0] st);
      return {pc, fd, fl, de, bb, fa, fb, st};
   endfunction

   task automatic drive(input stim_t s);
      rst_n               = s.rst;
      bus.id_valid        = s.v;
      bus.id_ra           = s.ra;
      bus.id_rb           = s.rb;
      bus.id_use_a        = s.ua;
      bus.id_use_b        = s.ub;
      bus.id_rd           = s.rd;
      bus.id_reg_write    = s.we;
      bus.id_mem_read     = s.ld;
      bus.ex_branch_taken = s.br;
      bus.mem_busy        = s.busy;
   endtask

   task automatic apply_reset;
      stim_t s;
      s = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      s.rst = 1'b0;
      @(posedge clk); #1;
      drive(s);
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      stim_t       s[4];
      logic [14:0] e[4];
      s[0] = mk(1, 3, 3, 1, 1, 3, 1, 0, 0, 0); s[0].rst = 1'b0; e[0] = ev(0,0,0,0,0,4'h0,4'h0,0);
      s[1] = mk(1, 3, 3, 1, 1, 3, 1, 1, 1, 0); s[1].rst = 1'b0; e[1] = ev(0,0,0,0,0,4'h0,4'h0,0);
      s[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);                 e[2] = ev(1,1,0,1,0,4'h0,4'h0,0);
      s[3] = mk(1, 3, 3, 1, 1, 5, 1, 0, 0, 0);                 e[3] = ev(1,1,0,1,0,4'h0,4'h0,0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         drive(s[i]);
         exp_q.push_back(e[i]);
         @(negedge clk);
         want = exp_q.pop_front();
         checks++;
         if (obs !== want) $display("FAIL reset step %0d: got %b expected %b", i, obs, want);
         else passed++;
      end
   endtask

   task automatic test_fwd_alu;
      stim_t       s[5];
      logic [14:0] e[5];
      apply_reset();
      s[0] = mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); e[0] = ev(1,1,0,1,0,4'h0,4'h0,0);
      s[1] = mk(1, 3, 3, 1, 0, 7, 1, 0, 0, 0); e[1] = ev(1,1,0,1,0,4'h1,4'h0,0);
      s[2] = mk(1, 3, 7, 1, 1, 0, 0, 0, 0, 0); e[2] = ev(1,1,0,1,0,4'h2,4'h1,0);
      s[3] = mk(1, 3, 7, 1, 1, 0, 0, 0, 0, 0); e[3] = ev(1,1,0,1,0,4'h4,4'h2,0);
      s[4] = mk(0, 3, 7, 1, 1, 0, 0, 0, 0, 0); e[4] = ev(1,1,0,1,0,4'h0,4'h0,0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         drive(s[i]);
         exp_q.push_back(e[i]);
         @(negedge clk);
         want = exp_q.pop_front();
         checks++;
         if (obs !== want) $display("FAIL fwd_alu step %0d: got %b expected %b", i, obs, want);
         else passed++;
      end
   endtask

   task automatic test_load_use;
      stim_t       s[4];
      logic [14:0] e[4];
      apply_reset();
      s[0] = mk(1, 0, 0, 0, 0, 5, 1, 1, 0, 0); e[0] = ev(1,1,0,1,0,4'h0,4'h0,0);
      s[1] = mk(1, 0, 5, 0, 1, 1, 1, 0, 0, 0); e[1] = ev(0,0,0,1,1,4'h0,4'h0,0);
      s[2] = mk(1, 0, 5, 0, 1, 1, 1, 0, 0, 0); e[2] = ev(1,1,0,1,0,4'h0,4'h2,1);
      s[3] = mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 0); e[3] = ev(1,1,0,1,0,4'h4,4'h0,0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         drive(s[i]);
         exp_q.push_back(e[i]);
         @(negedge clk);
         want = exp_q.pop_front();
         checks++;
         if (obs !== want) $display("FAIL load_use step %0d: got %b expected %b", i, obs, want);
         else passed++;
      end
   endtask

   task automatic test_branch;
      stim_t       s[4];
      logic [14:0] e[4];
      apply_reset();
      s[0] = mk(1, 0, 0, 0, 0, 2, 1, 0, 0, 0);   e[0] = ev(1,1,0,1,0,4'h0,4'h0,0);
      s[1] = mk(1, 0, 0, 0, 0, 9, 1, 0, 1, 0);   e[1] = ev(1,1,1,1,1,4'h0,4'h0,0);
      s[2] = mk(1, 0, 0, 0, 0, 10, 1, 0, 0, 0);  e[2] = ev(1,1,1,1,1,4'h0,4'h0,2);
      s[3] = mk(1, 2, 10, 1, 1, 0, 0, 0, 0, 0);  e[3] = ev(1,1,0,1,0,4'h4,4'h0,0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         drive(s[i]);
         exp_q.push_back(e[i]);
         @(negedge clk);
         want = exp_q.pop_front();
         checks++;
         if (obs !== want) $display("FAIL branch step %0d: got %b expected %b", i, obs, want);
         else passed++;
      end
   endtask

   task automatic test_busy_during_stall;
      stim_t       s[7];
      logic [14:0] e[7];
      apply_reset();
      s[0] = mk(1, 0, 0, 0, 0, 5, 1, 1, 0, 0); e[0] = ev(1,1,0,1,0,4'h0,4'h0,0);
      s[1] = mk(1, 0, 5, 0, 1, 1, 1, 0, 0, 0); e[1] = ev(0,0,0,1,1,4'h0,4'h0,0);
      s[2] = mk(1, 0, 5, 0, 1, 1, 1, 0, 0, 1); e[2] = ev(0,0,0,0,0,4'h0,4'h2,1);
      s[3] = mk(1, 0, 5, 0, 1, 1, 1, 0, 0, 1); e[3] = ev(0,0,0,0,0,4'h0,4'h2,3);
      s[4] = mk(1, 0, 5, 0, 1, 1, 1, 0, 0, 1); e[4] = ev(0,0,0,0,0,4'h0,4'h2,3);
      s[5] = mk(1, 0, 5, 0, 1, 1, 1, 0, 0, 0); e[5] = ev(1,1,0,1,0,4'h0,4'h2,3);
      s[6] = mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 0); e[6] = ev(1,1,0,1,0,4'h4,4'h0,0);
      for (int i = 0; i < 7; i++) begin
         @(posedge clk); #1;
         drive(s[i]);
         exp_q.push_back(e[i]);
         @(negedge clk);
         want = exp_q.pop_front();
         checks++;
         if (obs !== want) $display("FAIL busy_stall step %0d: got %b expected %b", i, obs, want);
         else passed++;
      end
   endtask

   task automatic test_branch_vs_load_use;
      stim_t       s[4];
      logic [14:0] e[4];
      apply_reset();
      s[0] = mk(1, 0, 0, 0, 0, 5, 1, 1, 0, 0); e[0] = ev(1,1,0,1,0,4'h0,4'h0,0);
      s[1] = mk(1, 0, 5, 0, 1, 1, 1, 0, 1, 0); e[1] = ev(1,1,1,1,1,4'h0,4'h0,0);
      s[2] = mk(1, 0, 5, 0, 1, 1, 1, 0, 0, 0); e[2] = ev(1,1,1,1,1,4'h0,4'h2,2);
      s[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[3] = ev(1,1,0,1,0,4'h0,4'h0,0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         drive(s[i]);
         exp_q.push_back(e[i]);
         @(negedge clk);
         want = exp_q.pop_front();
         checks++;
         if (obs !== want) $display("FAIL branch_vs_lu step %0d: got %b expected %b", i, obs, want);
         else passed++;
      end
   endtask

   task automatic test_reset_mid_flush;
      stim_t       s[4];
      logic [14:0] e[4];
      apply_reset();
      s[0] = mk(1, 0, 0, 0, 0, 4, 1, 0, 0, 0); e[0] = ev(1,1,0,1,0,4'h0,4'h0,0);
      s[1] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); e[1] = ev(1,1,1,1,1,4'h0,4'h0,0);
      s[2] = mk(1, 4, 4, 1, 1, 0, 0, 0, 0, 0); s[2].rst = 1'b0; e[2] = ev(0,0,0,0,0,4'h0,4'h0,0);
      s[3] = mk(1, 4, 4, 1, 1, 0, 0, 0, 0, 0); e[3] = ev(1,1,0,1,0,4'h0,4'h0,0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         drive(s[i]);
         exp_q.push_back(e[i]);
         @(negedge clk);
         want = exp_q.pop_front();
         checks++;
         if (obs !== want) $display("FAIL reset_mid_flush step %0d: got %b expected %b", i, obs, want);
         else passed++;
      end
   endtask

   task automatic test_back_to_back;
      stim_t       s[3];
      logic [14:0] e[3];
      logic [3:0]  r;
      logic [3:0]  o;
      for (int n = 0; n < 4; n++) begin
         apply_reset();
         r = 4'($urandom_range(1, 15));
         o = r + 4'($urandom_range(1, 15));
         s[0] = mk(1, 0, 0, 0, 0, r, 1, 0, 0, 0); e[0] = ev(1,1,0,1,0,4'h0,4'h0,0);
         s[1] = mk(1, r, o, 1, 1, r, 1, 0, 0, 0); e[1] = ev(1,1,0,1,0,4'h1,4'h0,0);
         s[2] = mk(1, r, r, 1, 1, 0, 0, 0, 0, 0); e[2] = ev(1,1,0,1,0,4'h1,4'h1,0);
         for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            want = exp_q.pop_front();
            checks++;
            if (obs !== want)
               $display("FAIL back_to_back r%0d step %0d: got %b expected %b", r, i, obs, want);
            else passed++;
         end
      end
   endtask

   // Test sequence and final report.
   initial begin
      checks = 0;
      passed = 0;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      rst_n = 1'b0;
      test_reset();
      test_fwd_alu();
      test_load_use();
      test_branch();
      test_busy_during_stall();
      test_branch_vs_load_use();
      test_reset_mid_flush();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Sequencer for the decode/execute pipeline register and the fetch/decode register in front of it. It tracks in-flight register writes through the execute, memory and writeback stages. It generates the stall, bubble and flush enables that freeze or squash the fetch, decode and decode/execute latches. It also produces the 4-bit operand-forwarding selects that travel with each instruction into execute. It sits beside the decode stage and is the only source of latch enables in the core.

## Interface
- BR_PENALTY, default 1: extra flush cycles after a taken branch, range 0..3.
- NREG, default 16: register-file size; register index width is clog2(NREG), 4 at default.
- clk  in  1  core clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset; one clock, reset is asynchronous and active-low
- id_valid  in  1  decode holds a real instruction
- id_ra, id_rb  in  4  source register indices of the decode instruction
- id_use_a, id_use_b  in  1  source actually read
- id_rd  in  4  destination index
- id_reg_write  in  1  decode instruction writes id_rd
- id_mem_read  in  1  decode instruction is a load
- ex_branch_taken  in  1  branch resolved taken in execute this cycle
- mem_busy  in  1  data memory not ready; whole pipe must hold
- pc_en  out  1  PC register load enable
- fd_en, fd_flush  out  1  fetch/decode latch enable and squash
- de_en, de_bubble  out  1  decode/execute latch enable and squash-to-NOP
- fwd_a_sel, fwd_b_sel  out  4  forwarding select for operands A/B, one-hot: 0000 register file, 0001 EX result, 0010 MEM result, 0100 WB result; bit 3 always 0
- hazard_state  out  2  current FSM state, for debug

## Operation
- Scoreboard: three slots EX, MEM, WB; each holds {valid, rd, we, is_load}.
- When the pipe advances (de_en=1), EX receives the decode instruction, or an invalid entry if de_bubble=1. MEM receives EX and WB receives MEM. WB is discarded.
- While mem_busy=1 all slots hold.
- Match rule: a slot matches source X when valid & we & rd==X & id_use_X & id_valid.
- Forward select picks the youngest matching slot, priority EX > MEM > WB; otherwise 0000.
- A load in EX is never forwarded; it raises a load-use stall instead.
- FSM states: RUN=0, LU_STALL=1, FLUSH=2, MEM_WAIT=3.
- Event priority within one cycle: mem_busy > ex_branch_taken > load-use.
- RUN:
  - mem_busy → MEM_WAIT, all enables 0.
  - Else ex_branch_taken → pc_en=1, fd_flush=1, de_bubble=1, de_en=1. Go to FLUSH if BR_PENALTY>0, else stay in RUN.
  - Else load-use (EX slot is_load and matches A or B) → pc_en=0, fd_en=0, de_en=1, de_bubble=1, go to LU_STALL.
  - Else all enables 1, no squash.
- LU_STALL: one cycle only. The load is now in MEM, so the operand forwards from MEM. Normal advance, return to RUN. mem_busy still has priority.
- FLUSH: down-counter loaded with BR_PENALTY. Each non-busy cycle asserts fd_flush=1 and de_bubble=1 with pc_en=1, and decrements. At 0, return to RUN. A new ex_branch_taken reloads the counter.
- MEM_WAIT: all enables 0, outputs otherwise held. On mem_busy=0, return to the state saved on entry and re-evaluate that cycle's events normally.
- A squashed instruction never sets scoreboard we.

## Timing
- pc_en, fd_*, de_*, fwd_* are combinational from the current state, scoreboard and inputs, valid in the same cycle.
- State, counter and scoreboard are registered.
- While rst_n=0:
  - state=RUN, counter=0, scoreboard slots invalid.
  - pc_en=fd_en=de_en=0, fd_flush=de_bubble=0, fwd_*=0000, hazard_state=0.
- First cycle after release: normal RUN behaviour.
- Reset asserted mid-stall or mid-flush clears everything immediately; no pending flush survives.
- Load-use latency: exactly 1 bubble cycle.
- Branch penalty: 1 + BR_PENALTY squashed decode slots.
- Simultaneous ex_branch_taken and load-use: the branch wins and no stall is taken, because the dependent instruction is squashed.
- Forwarding and the stall decision both use the pre-advance scoreboard.

## Structure
- Shared package pipe_pkg holds:
  - FSM state enum.
  - FWD_NONE/FWD_EX/FWD_MEM/FWD_WB constants.
  - Scoreboard slot struct.
  - REG_IDX_W.
- Natural sub-module: pipe_scoreboard, holding the 3-slot shift register plus the match/priority logic.
- The FSM stays in the top.

## Test plan
- Back-to-back ALU dependency: r3 written by an instruction in EX, decode reads r3 on A → fwd_a_sel=0001, no stall, all enables 1.
- Load-use on r5: load r5 in EX, decode reads r5 on B → one cycle with pc_en=0, fd_en=0, de_bubble=1. Next cycle fwd_b_sel=0010.
- Taken branch with BR_PENALTY=1: fd_flush=1 and de_bubble=1 for 2 consecutive cycles, pc_en=1 both cycles, then RUN.
- mem_busy held 3 cycles during LU_STALL: all enables 0 for 3 cycles, then the single LU_STALL advance completes, with no extra bubble.
- Branch and load-use in the same cycle: flush taken, no LU_STALL entry. rst_n pulsed low during FLUSH: outputs go to reset values immediately, and RUN resumes with an empty scoreboard.
